fwd_hazard_ctrl: RTL

//  Producer side of the EX-stage forwarding interface: generates SelFwA/SelFwB consumed by the EX forwarding muxes.

---
 rtl/fwd_pkg.sv | 23 ++
 rtl/fwd_sel_prio.sv | 36 +++
 rtl/fwd_hazard_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding / load-use hazard controller.
package fwd_pkg;

   // Widest register index a shadow entry can hold; narrower indices are zero-extended.
   localparam int REG_AW_MAX = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXM = 2'd1,
      FWD_MWB = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic                  valid;
      logic [REG_AW_MAX-1:0] rd;
      logic                  regwrite;
      logic                  memread;
   } shadow_t;

   typedef enum logic {IDLE, STALL} haz_state_e;

endpackage

// File: rtl/fwd_sel_prio.sv
// Priority forwarding select for one source operand; youngest producing stage wins.
module fwd_sel_prio
   import fwd_pkg::*;
#(
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] rs,
   input  shadow_t           ex,
   input  shadow_t           mem,
   input  shadow_t           wb,
   output logic [1:0]        sel,
   output logic              load_hit
);

   logic [REG_AW_MAX-1:0] rs_x;
   logic                  nz, h_ex, h_mem, h_wb;
   logic                  unused_memread;

   assign rs_x = REG_AW_MAX'(rs);
   // r0 is hardwired zero: never forwarded, never a hazard source
   assign nz    = |rs;
   assign h_ex  = nz & ex.valid  & ex.regwrite  & (ex.rd  == rs_x);
   assign h_mem = nz & mem.valid & mem.regwrite & (mem.rd == rs_x);
   assign h_wb  = nz & wb.valid  & wb.regwrite  & (wb.rd  == rs_x);

   assign load_hit       = h_ex & ex.memread;
   assign unused_memread = mem.memread ^ wb.memread;

   always_comb begin
      sel = FWD_RF;
      if (h_ex)       sel = FWD_EXM;
      else if (h_mem) sel = FWD_MWB;
      else if (h_wb)  sel = FWD_WB;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX forwarding-select generator and load-use stall controller.
// Define FWD_HAZ_PERF_EN to add saturating stall_cnt / fwd_cnt outputs.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter int REG_AW     = 4,
   parameter int LOAD_STALL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              regwrite_d,
   input  logic              memread_d,
   input  logic              flush,
   output logic [1:0]        SelFwA,
   output logic [1:0]        SelFwB,
   output logic              stall
`ifdef FWD_HAZ_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       fwd_cnt
`endif
);

   localparam int CNT_W = $clog2(LOAD_STALL + 1);

   shadow_t           ex_q, mem_q, wb_q;
   logic [1:0]        sel_a, sel_b;
   logic              ld_a, ld_b, hazard, bubble;
   haz_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;

   fwd_sel_prio #(.REG_AW(REG_AW)) u_sel_a (
      .rs(rs1_d), .ex(ex_q), .mem(mem_q), .wb(wb_q), .sel(sel_a), .load_hit(ld_a)
   );

   fwd_sel_prio #(.REG_AW(REG_AW)) u_sel_b (
      .rs(rs2_d), .ex(ex_q), .mem(mem_q), .wb(wb_q), .sel(sel_b), .load_hit(ld_b)
   );

   assign hazard = ld_a | ld_b;
   assign bubble = stall | flush | !valid_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt holds the stall cycles still owed after the current one
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: if (hazard) begin
               cnt_nxt = CNT_W'(LOAD_STALL - 1);
               if (LOAD_STALL > 1) state_nxt = STALL;
            end
            STALL: if (cnt <= CNT_W'(1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         endcase
      end
   end

   always_comb begin
      stall = 1'b0;
      if (!flush) stall = (state == STALL) | hazard;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q   <= '0;
         mem_q  <= '0;
         wb_q   <= '0;
         SelFwA <= FWD_RF;
         SelFwB <= FWD_RF;
      end else begin
         mem_q <= ex_q;
         wb_q  <= mem_q;
         if (bubble) begin
            ex_q   <= '0;
            SelFwA <= FWD_RF;
            SelFwB <= FWD_RF;
         end else begin
            ex_q   <= '{valid: 1'b1, rd: REG_AW_MAX'(rd_d),
                        regwrite: regwrite_d, memread: memread_d};
            SelFwA <= sel_a;
            SelFwB <= sel_b;
         end
      end
   end

`ifdef FWD_HAZ_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
         if ((SelFwA != 2'd0 || SelFwB != 2'd0) && fwd_cnt != '1)
            fwd_cnt <= fwd_cnt + 32'd1;
      end
   end
`endif

endmodule
